axi4lite_master: RTL

// Single-outstanding AXI4-Lite initiator; drives the AXI4-Lite slave/memory from a simple command port.

---
 rtl/axi4lite_master.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/axi4lite_master.sv
// Single-outstanding AXI4-Lite initiator: turns one command into AW/W/B or AR/R
// handshakes and reports completion, or a timeout abort, as a one-cycle response pulse.
module axi4lite_master #(
  parameter int unsigned addrWidth     = 32,
  parameter int unsigned dataWidth     = 32,
  parameter int unsigned strbWidth     = dataWidth / 8,
  parameter int unsigned timeoutCycles = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [addrWidth-1:0] cmd_addr,
  input  logic [dataWidth-1:0] cmd_wdata,
  input  logic [strbWidth-1:0] cmd_wstrb,
  output logic                 rsp_valid,
  output logic                 rsp_write,
  output logic [dataWidth-1:0] rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_timeout,
  output logic                 AWVALID,
  input  logic                 AWREADY,
  output logic [addrWidth-1:0] AWADDR,
  output logic [2:0]           AWPROT,
  output logic                 WVALID,
  input  logic                 WREADY,
  output logic [dataWidth-1:0] WDATA,
  output logic [strbWidth-1:0] WSTRB,
  input  logic                 BVALID,
  output logic                 BREADY,
  input  logic [1:0]           BRESP,
  output logic                 ARVALID,
  input  logic                 ARREADY,
  output logic [addrWidth-1:0] ARADDR,
  output logic [2:0]           ARPROT,
  input  logic                 RVALID,
  output logic                 RREADY,
  input  logic [dataWidth-1:0] RDATA,
  input  logic [1:0]           RRESP
);
  localparam int unsigned TimerWidth = $clog2(timeoutCycles + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(timeoutCycles - 1);
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                state;
  logic [addrWidth-1:0]  addr_q;
  logic                  write_q;
  logic [TimerWidth-1:0] timer;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                  progress, waiting, timed_out;

  // One registered address serves both channels; it only changes in IDLE.
  assign AWADDR = addr_q;
  assign ARADDR = addr_q;
  assign AWPROT = 3'b000;
  assign ARPROT = 3'b000;

  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // A wait state makes progress when it is about to leave for its successor.
  always_comb begin
    progress = 1'b0;
    waiting  = 1'b1;
    unique case (state)
      WR_REQ:  progress = (aw_hs | ~AWVALID) & (w_hs | ~WVALID);
      WR_RESP: progress = b_hs;
      RD_REQ:  progress = ar_hs;
      RD_RESP: progress = r_hs;
      default: waiting  = 1'b0;
    endcase
  end

  assign timed_out = waiting & ~progress & (timer == TimerLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      WDATA       <= '0;
      WSTRB       <= '0;
      AWVALID     <= 1'b0;
      WVALID      <= 1'b0;
      BREADY      <= 1'b0;
      ARVALID     <= 1'b0;
      RREADY      <= 1'b0;
      timer       <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= 2'b00;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      // Timer restarts on every state entry and never wraps (abort fires first).
      if (waiting && !progress) timer <= timer + 1'b1;
      else                      timer <= '0;

      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            addr_q    <= cmd_addr;
            write_q   <= cmd_write;
            WDATA     <= cmd_wdata;
            WSTRB     <= cmd_wstrb;
            if (cmd_write) begin
              AWVALID <= 1'b1;
              WVALID  <= 1'b1;
              state   <= WR_REQ;
            end else begin
              ARVALID <= 1'b1;
              state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (aw_hs) AWVALID <= 1'b0;
          if (w_hs)  WVALID  <= 1'b0;
          if (progress) begin
            BREADY <= 1'b1;
            state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            BREADY      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_resp    <= BRESP;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end
        end
        RD_REQ: begin
          if (ar_hs) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (r_hs) begin
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_write   <= 1'b0;
            rsp_rdata   <= RDATA;
            rsp_resp    <= RRESP;
            rsp_timeout <= 1'b0;
            state       <= DONE;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Abort overrides whatever the wait state scheduled above.
      if (timed_out) begin
        AWVALID     <= 1'b0;
        WVALID      <= 1'b0;
        BREADY      <= 1'b0;
        ARVALID     <= 1'b0;
        RREADY      <= 1'b0;
        timer       <= '0;
        rsp_valid   <= 1'b1;
        rsp_write   <= write_q;
        rsp_rdata   <= '0;
        rsp_resp    <= RespSlverr;
        rsp_timeout <= 1'b1;
        state       <= DONE;
      end
    end
  end
endmodule
